// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception controller: FSM states, vector bit
// positions, processor modes and the exception priority order.
package exception_controller_pkg;

    typedef enum logic [1:0] {
        ST_RSTWAIT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_VECTOR  = 2'd2,
        ST_REFILL  = 2'd3
    } exc_state_e;

    localparam int NUM_VEC = 7;

    localparam logic [2:0] VEC_RESET = 3'd0;
    localparam logic [2:0] VEC_UNDEF = 3'd1;
    localparam logic [2:0] VEC_SWI   = 3'd2;
    localparam logic [2:0] VEC_PABT  = 3'd3;
    localparam logic [2:0] VEC_DABT  = 3'd4;
    localparam logic [2:0] VEC_IRQ   = 3'd5;
    localparam logic [2:0] VEC_FIQ   = 3'd6;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    // Highest priority first; reset never competes, it is issued from RSTWAIT.
    localparam int NUM_PRIO = 6;
    localparam logic [2:0] PRIO_ORDER [NUM_PRIO] = '{
        VEC_DABT, VEC_FIQ, VEC_IRQ, VEC_PABT, VEC_UNDEF, VEC_SWI
    };

    // Returns the one-hot of the highest-priority asserted request.
    function automatic logic [NUM_VEC-1:0] pick_vector(input logic [NUM_VEC-1:0] req);
        logic [NUM_VEC-1:0] win;
        win = '0;
        for (int i = NUM_PRIO - 1; i >= 0; i--) begin
            if (req[PRIO_ORDER[i]]) begin
                win = 7'(1) << PRIO_ORDER[i];
            end
        end
        return win;
    endfunction

    function automatic logic [4:0] mode_for(input logic [NUM_VEC-1:0] vec);
        logic [4:0] mode;
        if (vec[VEC_FIQ]) begin
            mode = MODE_FIQ;
        end else if (vec[VEC_IRQ]) begin
            mode = MODE_IRQ;
        end else if (vec[VEC_DABT] || vec[VEC_PABT]) begin
            mode = MODE_ABT;
        end else if (vec[VEC_UNDEF]) begin
            mode = MODE_UND;
        end else begin
            mode = MODE_SVC;
        end
        return mode;
    endfunction

endpackage

// File: rtl/exception_controller_sync_nflop.sv
// N-flop synchronizer for asynchronous level inputs; clears to 0 on reset.
module sync_nflop #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/exception_controller.sv
// Writeback-stage exception controller: arbitrates synchronous exceptions and
// synchronized IRQ/FIQ, issues one vector/flush, then blocks interrupts during refill.
module exception_controller
    import exception_controller_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int REFILL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallW,
    input  logic       InstrValidW,
    input  logic       UndefW,
    input  logic       SWIW,
    input  logic       PrefetchAbortW,
    input  logic       DataAbortW,
    input  logic       IRQ,
    input  logic       FIQ,
    input  logic       CPSR_I,
    input  logic       CPSR_F,
    output logic [6:0] PCVectorAddressW,
    output logic       ExceptionFlushW,
    output logic [4:0] NewModeW,
    output logic       ExceptionTakenW,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] RSTWAIT = ST_RSTWAIT;
    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] VECTOR  = ST_VECTOR;
    localparam logic [1:0] REFILL  = ST_REFILL;

    localparam int CNT_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFILL_CYCLES - 1);

    logic             irq_s, fiq_s;
    logic [1:0]       state_q, state_d;
    logic [6:0]       vec_q, vec_d;
    logic [4:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       req, win;
    logic             take_ok;
    logic [6:0]       pc_q;
    logic             flush_q, taken_q;

    sync_nflop #(.DEPTH(SYNC_STAGES)) u_sync_irq (
        .clk   (clk),
        .rst_n (reset),
        .d     (IRQ),
        .q     (irq_s)
    );

    sync_nflop #(.DEPTH(SYNC_STAGES)) u_sync_fiq (
        .clk   (clk),
        .rst_n (reset),
        .d     (FIQ),
        .q     (fiq_s)
    );

    // Interrupts only compete in IDLE; REFILL sees the synchronous exceptions alone.
    always_comb begin
        req            = '0;
        req[VEC_DABT]  = DataAbortW;
        req[VEC_PABT]  = PrefetchAbortW;
        req[VEC_UNDEF] = UndefW;
        req[VEC_SWI]   = SWIW;
        if (state_q == IDLE) begin
            req[VEC_FIQ] = fiq_s && !CPSR_F;
            req[VEC_IRQ] = irq_s && !CPSR_I;
        end
        win     = pick_vector(req);
        take_ok = InstrValidW && !StallW;
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            RSTWAIT: begin
                state_d = VECTOR;
                vec_d   = 7'(1) << VEC_RESET;
                mode_d  = MODE_SVC;
            end
            IDLE: begin
                if (take_ok && (win != '0)) begin
                    state_d = VECTOR;
                    vec_d   = win;
                    mode_d  = mode_for(win);
                end
            end
            VECTOR: begin
                if (!StallW) begin
                    state_d = REFILL;
                    cnt_d   = CNT_LOAD;
                end
            end
            REFILL: begin
                if (take_ok && (win != '0)) begin
                    state_d = VECTOR;
                    vec_d   = win;
                    mode_d  = mode_for(win);
                end else if (!StallW) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = RSTWAIT;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RSTWAIT;
            vec_q   <= '0;
            mode_q  <= MODE_SVC;
            cnt_q   <= '0;
            pc_q    <= '0;
            flush_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            pc_q    <= (state_d == VECTOR) ? vec_d : '0;
            flush_q <= (state_d == VECTOR);
            taken_q <= (state_d == VECTOR) && !vec_d[VEC_RESET];
        end
    end

    assign PCVectorAddressW = pc_q;
    assign ExceptionFlushW  = flush_q;
    assign ExceptionTakenW  = taken_q;
    assign NewModeW         = mode_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: directed scenarios plus random traffic, checked
// every cycle against a phase-level reference model and a vector scoreboard.
module tb_exception_controller;

    localparam int SYNC_STAGES   = 2;
    localparam int REFILL_CYCLES = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       StallW, InstrValidW, UndefW, SWIW, PrefetchAbortW, DataAbortW;
    logic       IRQ, FIQ, CPSR_I, CPSR_F;
    logic [6:0] PCVectorAddressW;
    logic       ExceptionFlushW;
    logic [4:0] NewModeW;
    logic       ExceptionTakenW;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    exception_controller #(
        .SYNC_STAGES   (SYNC_STAGES),
        .REFILL_CYCLES (REFILL_CYCLES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .StallW           (StallW),
        .InstrValidW      (InstrValidW),
        .UndefW           (UndefW),
        .SWIW             (SWIW),
        .PrefetchAbortW   (PrefetchAbortW),
        .DataAbortW       (DataAbortW),
        .IRQ              (IRQ),
        .FIQ              (FIQ),
        .CPSR_I           (CPSR_I),
        .CPSR_F           (CPSR_F),
        .PCVectorAddressW (PCVectorAddressW),
        .ExceptionFlushW  (ExceptionFlushW),
        .NewModeW         (NewModeW),
        .ExceptionTakenW  (ExceptionTakenW),
        .dbg_state        (dbg_state)
    );

    int checks_n = 0;
    int errors_n = 0;
    logic [6:0] exp_q[$];
    logic prev_flush = 1'b0;

    // Reference model: phase, latched vector/mode, remaining unstalled refill cycles.
    typedef enum {P_WAIT, P_IDLE, P_VECTOR, P_REFILL} phase_e;
    phase_e     m_phase;
    logic [6:0] m_vec;
    logic [4:0] m_mode;
    int         m_left;
    bit         m_irq_pipe[$];
    bit         m_fiq_pipe[$];
    logic [4:0] mode_tab [7] = '{5'b10011, 5'b11011, 5'b10011, 5'b10111,
                                 5'b10111, 5'b10010, 5'b10001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_WAIT;
        m_vec   = '0;
        m_mode  = 5'b10011;
        m_left  = 0;
        m_irq_pipe.delete();
        m_fiq_pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_irq_pipe.push_back(1'b0);
            m_fiq_pipe.push_back(1'b0);
        end
    endtask

    task automatic model_enter(input int b);
        m_phase = P_VECTOR;
        m_vec   = 7'(1) << b;
        m_mode  = mode_tab[b];
        exp_q.push_back(m_vec);
    endtask

    // Advances the model across the coming rising edge using the current inputs.
    task automatic model_step();
        bit irq_seen, fiq_seen, take_ok, ints;
        int win;
        if (!reset) begin
            model_reset();
            return;
        end
        irq_seen = m_irq_pipe[SYNC_STAGES-1];
        fiq_seen = m_fiq_pipe[SYNC_STAGES-1];
        m_irq_pipe.push_front(IRQ);
        void'(m_irq_pipe.pop_back());
        m_fiq_pipe.push_front(FIQ);
        void'(m_fiq_pipe.pop_back());
        take_ok = InstrValidW && !StallW;
        ints    = (m_phase == P_IDLE);
        win     = -1;
        if (take_ok && (m_phase == P_IDLE || m_phase == P_REFILL)) begin
            if (DataAbortW)                         win = 4;
            else if (ints && fiq_seen && !CPSR_F)   win = 6;
            else if (ints && irq_seen && !CPSR_I)   win = 5;
            else if (PrefetchAbortW)                win = 3;
            else if (UndefW)                        win = 1;
            else if (SWIW)                          win = 2;
        end
        case (m_phase)
            P_WAIT:   model_enter(0);
            P_IDLE:   if (win >= 0) model_enter(win);
            P_VECTOR: if (!StallW) begin
                          m_phase = P_REFILL;
                          m_left  = REFILL_CYCLES;
                      end
            P_REFILL: if (win >= 0) begin
                          model_enter(win);
                      end else if (!StallW) begin
                          m_left--;
                          if (m_left == 0) m_phase = P_IDLE;
                      end
            default:  m_phase = P_WAIT;
        endcase
    endtask

    task automatic tick();
        logic [6:0] exp_pc;
        model_step();
        @(posedge clk);
        @(negedge clk);
        exp_pc = (m_phase == P_VECTOR) ? m_vec : 7'b0;
        check("pc",    32'(PCVectorAddressW), 32'(exp_pc));
        check("flush", 32'(ExceptionFlushW),  32'(m_phase == P_VECTOR));
        check("taken", 32'(ExceptionTakenW),  32'(m_phase == P_VECTOR && !m_vec[0]));
        check("mode",  32'(NewModeW),         32'(m_mode));
        if (ExceptionFlushW && !prev_flush) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else                   check("sb_vector", 32'(PCVectorAddressW), 32'(exp_q.pop_front()));
        end
        prev_flush = ExceptionFlushW;
    endtask

    task automatic clear_inputs();
        StallW = 0; InstrValidW = 0; UndefW = 0; SWIW = 0;
        PrefetchAbortW = 0; DataAbortW = 0; IRQ = 0; FIQ = 0;
        CPSR_I = 0; CPSR_F = 0;
    endtask

    initial begin
        int lat, cnt;
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) tick();

        // Release with no stimulus: one reset vector, four refill cycles, idle.
        reset = 1'b1;
        tick();
        check("rst_vec_pc",    32'(PCVectorAddressW), 32'h01);
        check("rst_vec_taken", 32'(ExceptionTakenW),  32'd0);
        check("rst_vec_mode",  32'(NewModeW),         32'h13);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(ExceptionFlushW);
        end
        check("rst_refill_flush", 32'(cnt), 32'd0);

        // FIQ beats IRQ; taken on the third edge after the request is driven.
        IRQ = 1; FIQ = 1; InstrValidW = 1;
        lat = 0;
        for (int i = 0; i < 10 && !ExceptionFlushW; i++) begin
            tick();
            lat++;
        end
        check("fiq_latency", 32'(lat),              32'd3);
        check("fiq_pc",      32'(PCVectorAddressW), 32'h40);
        check("fiq_mode",    32'(NewModeW),         32'h11);
        IRQ = 0; FIQ = 0; InstrValidW = 0;
        repeat (8) tick();

        // Data abort beats pending FIQ and SWI.
        FIQ = 1;
        repeat (3) tick();
        InstrValidW = 1; DataAbortW = 1; SWIW = 1;
        tick();
        check("dabt_pc",   32'(PCVectorAddressW), 32'h10);
        check("dabt_mode", 32'(NewModeW),         32'h17);
        clear_inputs();
        repeat (8) tick();

        // Undef vector held by a 3-cycle stall.
        UndefW = 1; SWIW = 1; InstrValidW = 1;
        tick();
        check("undef_pc", 32'(PCVectorAddressW), 32'h02);
        cnt = int'(ExceptionFlushW);
        UndefW = 0; SWIW = 0; InstrValidW = 0; StallW = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += int'(ExceptionFlushW);
        end
        StallW = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt += int'(ExceptionFlushW);
        end
        check("undef_flush_cycles", 32'(cnt), 32'd4);

        // IRQ held through refill is taken only once idle.
        SWIW = 1; InstrValidW = 1;
        tick();
        SWIW = 0;
        tick();
        IRQ = 1;
        lat = 0;
        for (int i = 0; i < 12 && !ExceptionFlushW; i++) begin
            tick();
            lat++;
        end
        check("irq_refill_latency", 32'(lat),              32'd5);
        check("irq_refill_pc",      32'(PCVectorAddressW), 32'h20);
        IRQ = 0; InstrValidW = 0;
        repeat (8) tick();

        // IRQ pulse confined to refill is dropped.
        SWIW = 1; InstrValidW = 1;
        tick();
        SWIW = 0;
        tick();
        IRQ = 1;
        tick();
        IRQ = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(ExceptionFlushW);
        end
        check("irq_dropped_flush", 32'(cnt), 32'd0);
        InstrValidW = 0;

        // Reset during an IRQ vector abandons it.
        IRQ = 1; InstrValidW = 1;
        for (int i = 0; i < 6 && !ExceptionFlushW; i++) tick();
        check("irq_before_rst", 32'(PCVectorAddressW), 32'h20);
        StallW = 1;
        tick();
        reset = 0; IRQ = 0;
        tick();
        check("rst_mid_pc",    32'(PCVectorAddressW), 32'h00);
        check("rst_mid_flush", 32'(ExceptionFlushW),  32'd0);
        check("rst_mid_mode",  32'(NewModeW),         32'h13);
        tick();
        reset = 1; StallW = 0;
        tick();
        check("rst_again_pc", 32'(PCVectorAddressW), 32'h01);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(PCVectorAddressW[5]);
        end
        check("irq_never_issued", 32'(cnt), 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            reset          = (n < 2990) ? ($urandom_range(0, 199) != 0) : 1'b1;
            StallW         = ($urandom_range(0, 3) == 0);
            InstrValidW    = ($urandom_range(0, 3) != 0);
            UndefW         = ($urandom_range(0, 11) == 0);
            SWIW           = ($urandom_range(0, 11) == 0);
            PrefetchAbortW = ($urandom_range(0, 15) == 0);
            DataAbortW     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) IRQ = ~IRQ;
            if ($urandom_range(0, 13) == 0) FIQ = ~FIQ;
            if ($urandom_range(0, 7) == 0) CPSR_I = ~CPSR_I;
            if ($urandom_range(0, 7) == 0) CPSR_F = ~CPSR_F;
            tick();
        end
        clear_inputs();
        repeat (8) tick();
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
